// File: rtl/truth_table_sequencer.sv
// Steps a 4-bit vector through two circuits under test, compares their outputs; one vector per SETTLE_CYCLES+1 cycles
// plus HOLD_CYCLES (auto) or a step pulse (manual); no backpressure, start is ignored while busy.
module truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step,
    input  logic       mode,
    input  logic       f_pre,
    input  logic       f_post,
    output logic [3:0] vec,
    output logic       busy,
    output logic       done,
    output logic [4:0] mismatch_cnt,
    output logic [3:0] first_err_vec,
    output logic       err_valid,
    output logic       led_pre_q,
    output logic       led_post_q
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SAMPLE,
        HOLD,
        DONE
    } state_t;

    localparam int CNT_W = 26;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [4:0]       CNT_MAX     = 5'd16;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mode_q, mode_nxt;
    logic [3:0]       vec_nxt;
    logic             busy_nxt, done_nxt;
    logic [4:0]       mismatch_nxt;
    logic [3:0]       first_err_nxt;
    logic             err_valid_nxt;
    logic             led_pre_nxt, led_post_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            mode_q        <= 1'b0;
            vec           <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mismatch_cnt  <= 5'd0;
            first_err_vec <= 4'd0;
            err_valid     <= 1'b0;
            led_pre_q     <= 1'b0;
            led_post_q    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            mode_q        <= mode_nxt;
            vec           <= vec_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            mismatch_cnt  <= mismatch_nxt;
            first_err_vec <= first_err_nxt;
            err_valid     <= err_valid_nxt;
            led_pre_q     <= led_pre_nxt;
            led_post_q    <= led_post_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        mode_nxt      = mode_q;
        vec_nxt       = vec;
        mismatch_nxt  = mismatch_cnt;
        first_err_nxt = first_err_vec;
        err_valid_nxt = err_valid;
        led_pre_nxt   = led_pre_q;
        led_post_nxt  = led_post_q;

        case (state)
            IDLE, DONE: begin
                // start outranks step here; step has no meaning outside manual HOLD
                if (start) begin
                    mode_nxt      = mode;
                    mismatch_nxt  = 5'd0;
                    first_err_nxt = 4'd0;
                    err_valid_nxt = 1'b0;
                    vec_nxt       = 4'd0;
                    cnt_nxt       = '0;
                    state_nxt     = APPLY;
                end
            end
            APPLY: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SAMPLE: begin
                led_pre_nxt  = f_pre;
                led_post_nxt = f_post;
                if (f_pre != f_post) begin
                    if (mismatch_cnt != CNT_MAX) begin
                        mismatch_nxt = mismatch_cnt + 5'd1;
                    end
                    if (!err_valid) begin
                        first_err_nxt = vec;
                        err_valid_nxt = 1'b1;
                    end
                end
                cnt_nxt   = '0;
                state_nxt = (vec == 4'd15) ? DONE : HOLD;
            end
            HOLD: begin
                if (mode_q) begin
                    if (step) begin
                        vec_nxt   = vec + 4'd1;
                        state_nxt = APPLY;
                    end
                end else if (cnt == HOLD_LAST) begin
                    cnt_nxt   = '0;
                    vec_nxt   = vec + 4'd1;
                    state_nxt = APPLY;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // status flags are registered from the next state so they line up with it
        busy_nxt = (state_nxt == APPLY) || (state_nxt == SAMPLE) || (state_nxt == HOLD);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Randomised scans of truth_table_sequencer checked cycle by cycle against a timeline model of the scan.
module tb_truth_table_sequencer;

    localparam int S   = 2;
    localparam int H   = 3;
    localparam int P   = S + 1 + H;
    localparam int LAT = 16 * (S + 1) + 15 * H;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic       step   = 1'b0;
    logic       mode   = 1'b0;
    logic       f_pre, f_post;
    logic [3:0] vec, first_err_vec;
    logic       busy, done, err_valid, led_pre_q, led_post_q;
    logic [4:0] mismatch_cnt;

    logic [15:0] tt_pre  = 16'h0;
    logic [15:0] tt_post = 16'h0;
    logic        m_led_pre  = 1'b0;
    logic        m_led_post = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign f_pre  = tt_pre[vec];
    assign f_post = tt_post[vec];

    truth_table_sequencer #(
        .SETTLE_CYCLES(S),
        .HOLD_CYCLES  (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .step         (step),
        .mode         (mode),
        .f_pre        (f_pre),
        .f_post       (f_post),
        .vec          (vec),
        .busy         (busy),
        .done         (done),
        .mismatch_cnt (mismatch_cnt),
        .first_err_vec(first_err_vec),
        .err_valid    (err_valid),
        .led_pre_q    (led_pre_q),
        .led_post_q   (led_post_q)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // vectors whose SAMPLE exit edge has happened n edges after the start edge
    function automatic int n_sampled(input int n);
        int k;
        if (n < S + 1) return 0;
        k = (n - S - 1) / P + 1;
        return (k > 16) ? 16 : k;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_vec"}, vec, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cnt"}, mismatch_cnt, 0);
        chk({tag, "_ferr"}, first_err_vec, 0);
        chk({tag, "_evld"}, err_valid, 0);
        chk({tag, "_lpre"}, led_pre_q, 0);
        chk({tag, "_lpost"}, led_post_q, 0);
    endtask

    // Called at a negedge; start is seen on the next posedge (edge 0 of the scan).
    task automatic run_auto(input logic with_step, input int abort_at);
        int k, diff, fe, ev;
        logic ev_valid;
        mode  = 1'b0;
        start = 1'b1;
        step  = with_step;
        @(negedge clk);
        start = 1'b0;
        step  = 1'b0;
        for (int n = 0; n <= LAT; n++) begin
            if (n > 0) @(negedge clk);
            k        = n_sampled(n);
            diff     = int'(tt_pre ^ tt_post) & ((1 << k) - 1);
            fe       = 0;
            ev_valid = 1'b0;
            for (int i = 15; i >= 0; i--) begin
                if (diff[i]) begin
                    fe       = i;
                    ev_valid = 1'b1;
                end
            end
            ev = (n / P > 15) ? 15 : n / P;
            chk("auto_vec", vec, ev);
            chk("auto_busy", busy, (n < LAT) ? 1 : 0);
            chk("auto_done", done, (n >= LAT) ? 1 : 0);
            chk("auto_cnt", mismatch_cnt, $countones(diff));
            chk("auto_evld", err_valid, ev_valid);
            chk("auto_ferr", first_err_vec, fe);
            chk("auto_lpre", led_pre_q, (k == 0) ? m_led_pre : tt_pre[k-1]);
            chk("auto_lpost", led_post_q, (k == 0) ? m_led_post : tt_post[k-1]);
            if (n == abort_at) return;
            mode  = 1'($urandom);
            step  = 1'($urandom);
            start = ($urandom_range(0, 9) == 0) && (n + 1 < LAT);
        end
        start      = 1'b0;
        step       = 1'b0;
        m_led_pre  = tt_pre[15];
        m_led_post = tt_post[15];
    endtask

    // Manual scan: random steps for rand_cycles, then a step every cycle until the scan completes.
    task automatic run_manual(input int rand_cycles);
        int   ph, mv;
        logic md, sv;
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ph = 0;
        mv = 0;
        md = 1'b0;
        for (int n = 0; n < rand_cycles + 100; n++) begin
            if (n > 0) @(negedge clk);
            chk("man_vec", vec, mv);
            chk("man_busy", busy, md ? 0 : 1);
            chk("man_done", done, md ? 1 : 0);
            sv   = (n < rand_cycles) ? ($urandom_range(0, 3) == 0) : 1'b1;
            step = sv;
            mode = 1'($urandom);
            if (!md) begin
                if (ph == S && mv == 15) md = 1'b1;
                else if (ph >= S + 1 && sv) begin
                    mv++;
                    ph = 0;
                end else ph++;
            end
        end
        step = 1'b0;
        chk("man_end_done", done, 1);
        chk("man_end_cnt", mismatch_cnt, $countones(tt_pre ^ tt_post));
        chk("man_end_lpre", led_pre_q, tt_pre[15]);
        m_led_pre  = tt_pre[15];
        m_led_post = tt_post[15];
    endtask

    initial begin
        logic [3:0] v;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        tt_pre  = 16'($urandom);
        tt_post = tt_pre;
        run_auto(1'b0, -1);

        tt_pre  = 16'($urandom);
        tt_post = tt_pre ^ 16'h1020;
        run_auto(1'b0, -1);

        repeat (3) begin
            tt_pre  = 16'($urandom);
            tt_post = 16'($urandom);
            run_auto(1'b0, -1);
        end

        tt_pre  = 16'($urandom);
        tt_post = ~tt_pre;
        run_auto(1'b1, -1);

        tt_pre  = 16'($urandom);
        tt_post = 16'($urandom);
        run_manual(40);

        run_auto(1'b1, -1);

        // asynchronous reset while vec = 7
        tt_pre  = 16'($urandom);
        tt_post = 16'($urandom);
        run_auto(1'b0, 7 * P + int'($urandom_range(0, P - 1)));
        start = 1'b0;
        step  = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        @(negedge clk);
        rst        = 1'b0;
        m_led_pre  = 1'b0;
        m_led_post = 1'b0;
        run_auto(1'b0, -1);

        // real circuits: f = a c + c' d, hazard-free version adds consensus a d
        for (int i = 0; i < 16; i++) begin
            v          = 4'(i);
            tt_pre[i]  = (v[0] & v[2]) | (~v[2] & v[3]);
            tt_post[i] = (v[0] & v[2]) | (~v[2] & v[3]) | (v[0] & v[3]);
        end
        run_auto(1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
